vit_feed_ctrl: RTL and testbench

Flow controller that sits between the deinterleaver and the Viterbi decoder core inside the OFDM decoder. It buffers deinterleaved soft-bit pairs, presents them over a proper AXI-Stream valid/ready handshake, and appends tail-flush pairs once the programmed bit count has been consumed. It counts decoded output bits and signals completion per field (SIG, HT-SIG, DATA). It replaces the static one-cycle-delay feeding of the Viterbi core.

---
 rtl/vit_feed_ctrl_if.sv | 11 +
 rtl/vit_feed_ctrl.sv | 171 +++++++++++++++++
 tb/tb_vit_feed_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vit_feed_ctrl_if.sv
// Soft-bit stream from the feed controller into the Viterbi decoder core.
// tdata carries {5'b0, soft1, 5'b0, soft0}; tuser carries {6'b0, erase}.
interface vit_feed_ctrl_if;
  logic [15:0] vit_tdata;
  logic [7:0]  vit_tuser;
  logic        vit_tvalid;
  logic        vit_tready;

  modport master (output vit_tdata, output vit_tuser, output vit_tvalid, input vit_tready);
  modport slave  (input vit_tdata, input vit_tuser, input vit_tvalid, output vit_tready);
endinterface

// File: rtl/vit_feed_ctrl.sv
// Viterbi feed controller: buffers deinterleaved soft-bit pairs in a small
// first-word-fall-through FIFO, presents them on a valid/ready stream, appends
// tail-flush pairs once the programmed pair count is in, and counts decoded
// bits to signal the end of each field (SIG, HT-SIG, DATA).
module vit_feed_ctrl #(
  parameter int FIFO_AW   = 3,
  parameter int FLUSH_MAX = 256
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    start,
  input  logic [19:0]             num_bits_to_decode,
  input  logic [5:0]              in_bits,
  input  logic [1:0]              in_erase,
  input  logic                    in_stb,
  vit_feed_ctrl_if.master         vit,
  input  logic                    vit_out_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout,
  output logic                    overflow,
  output logic [19:0]             in_count,
  output logic [19:0]             dec_count
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int FC_W  = $clog2(FLUSH_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [19:0]        target_q, target_d;
  logic [19:0]        in_count_q, in_count_d;
  logic [19:0]        dec_count_q, dec_count_d;
  logic [FC_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic               timeout_q, timeout_d;
  logic               overflow_q, overflow_d;

  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   occ_q;
  logic [7:0]         mem_q [DEPTH];

  logic               fifo_empty, fifo_full, fifo_rd, fifo_wr, fifo_clr;
  logic               feeding, flushing, tvalid, xfer, flush_acc, wr_req;
  logic [7:0]         head;

  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == (FIFO_AW + 1)'(DEPTH));
  assign head       = mem_q[rd_ptr_q];
  assign feeding    = (state_q == S_FEED);
  assign flushing   = (state_q == S_FLUSH);

  // Stream side: FIFO head first, the fixed flush pair only once the FIFO has drained.
  assign tvalid    = enable & ((feeding & ~fifo_empty) | flushing);
  assign xfer      = tvalid & vit.vit_tready;
  assign fifo_rd   = xfer & ~fifo_empty;
  assign flush_acc = xfer & fifo_empty & flushing;

  // Accepted pairs count toward the target even when the FIFO is full and the pair is lost.
  assign wr_req   = enable & feeding & in_stb & (in_count_q < target_q);
  assign fifo_wr  = wr_req & (~fifo_full | fifo_rd);
  assign fifo_clr = enable & (state_q == S_DONE);

  // Drive the stream outputs; an empty FIFO outside FLUSH shows all-zero data.
  always_comb begin
    vit.vit_tdata  = 16'h0000;
    vit.vit_tuser  = 8'h00;
    vit.vit_tvalid = tvalid;
    if (!fifo_empty) begin
      vit.vit_tdata = {5'b0, head[5:3], 5'b0, head[2:0]};
      vit.vit_tuser = {6'b0, head[7:6]};
    end else if (flushing) begin
      vit.vit_tdata = 16'h0303;
      vit.vit_tuser = 8'h00;
    end
  end

  // FIFO storage; contents are qualified by the occupancy count, so no reset is needed.
  always_ff @(posedge clock) begin
    if (!reset && fifo_wr) mem_q[wr_ptr_q] <= {in_erase, in_bits};
  end

  // FIFO pointers and occupancy; emptied on reset and at field end.
  always_ff @(posedge clock) begin
    if (reset || fifo_clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (fifo_rd) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      if (fifo_wr && !fifo_rd)      occ_q <= occ_q + (FIFO_AW + 1)'(1);
      else if (fifo_rd && !fifo_wr) occ_q <= occ_q - (FIFO_AW + 1)'(1);
    end
  end

  // Next-state and counter logic; nothing moves while enable is low.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    in_count_d  = in_count_q;
    dec_count_d = dec_count_q;
    flush_cnt_d = flush_cnt_q;
    timeout_d   = timeout_q;
    overflow_d  = overflow_q;
    if (enable) begin
      if (wr_req) in_count_d = in_count_q + 20'd1;
      if (wr_req && fifo_full && !fifo_rd) overflow_d = 1'b1;
      if ((feeding || flushing) && vit_out_valid && (dec_count_q != 20'hFFFFF))
        dec_count_d = dec_count_q + 20'd1;
      if (flush_acc) flush_cnt_d = flush_cnt_q + FC_W'(1);
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            target_d    = num_bits_to_decode;
            in_count_d  = '0;
            dec_count_d = '0;
            flush_cnt_d = '0;
            timeout_d   = 1'b0;
            overflow_d  = 1'b0;
            state_d     = S_FEED;
          end
        end
        S_FEED: begin
          if (in_count_q == target_q) state_d = S_FLUSH;
        end
        S_FLUSH: begin
          // The last permitted flush pair ends the field on its own acceptance edge.
          if (dec_count_q >= target_q) begin
            state_d = S_DONE;
          end else if (flush_acc && (flush_cnt_q == FC_W'(FLUSH_MAX - 1))) begin
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      target_q    <= '0;
      in_count_q  <= '0;
      dec_count_q <= '0;
      flush_cnt_q <= '0;
      timeout_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      in_count_q  <= in_count_d;
      dec_count_q <= dec_count_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = enable & (state_q == S_DONE);
  assign timeout   = timeout_q;
  assign overflow  = overflow_q;
  assign in_count  = in_count_q;
  assign dec_count = dec_count_q;

endmodule

// File: tb/tb_vit_feed_ctrl.sv
// Directed bench for vit_feed_ctrl: basic field, backpressure, overflow,
// excess input, zero target, flush timeout, enable freeze, reset mid-field
// and start while busy.
module tb_vit_feed_ctrl;

  logic        clock = 1'b0;
  logic        reset, enable, start, in_stb, vit_out_valid;
  logic [19:0] num_bits_to_decode;
  logic [5:0]  in_bits;
  logic [1:0]  in_erase;
  logic        busy, done, timeout, overflow;
  logic [19:0] in_count, dec_count;

  vit_feed_ctrl_if vif ();

  vit_feed_ctrl #(.FIFO_AW(3), .FLUSH_MAX(256)) dut (
    .clock              (clock),
    .reset              (reset),
    .enable             (enable),
    .start              (start),
    .num_bits_to_decode (num_bits_to_decode),
    .in_bits            (in_bits),
    .in_erase           (in_erase),
    .in_stb             (in_stb),
    .vit                (vif.master),
    .vit_out_valid      (vit_out_valid),
    .busy               (busy),
    .done               (done),
    .timeout            (timeout),
    .overflow           (overflow),
    .in_count           (in_count),
    .dec_count          (dec_count)
  );

  always #5 clock = ~clock;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  int          stall_viol = 0;
  logic [23:0] xq[$];
  logic        prev_stall = 1'b0;
  logic [23:0] prev_word = '0;

  // Transfer log, done-pulse counter and stall-stability watch, sampled mid-cycle.
  always @(negedge clock) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (done) done_cnt <= done_cnt + 1;
      if (prev_stall && vif.vit_tvalid && ({vif.vit_tuser, vif.vit_tdata} != prev_word))
        stall_viol <= stall_viol + 1;
      if (vif.vit_tvalid && vif.vit_tready) xq.push_back({vif.vit_tuser, vif.vit_tdata});
      prev_stall <= vif.vit_tvalid && !vif.vit_tready;
      prev_word  <= {vif.vit_tuser, vif.vit_tdata};
    end
  end

  function automatic logic [7:0] pair_val(input int i);
    logic [5:0] b;
    logic [1:0] e;
    b = 6'((i * 13 + 5) % 64);
    e = 2'((i % 3) + 1);
    return {e, b};
  endfunction

  function automatic logic [23:0] exp_word(input logic [7:0] p);
    return {6'b0, p[7:6], 5'b0, p[5:3], 5'b0, p[2:0]};
  endfunction

  function automatic int count_flush(input int q0);
    int c = 0;
    for (int k = q0; k < xq.size(); k++) if (xq[k] == 24'h000303) c++;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [19:0] n);
    num_bits_to_decode = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      {in_erase, in_bits} = pair_val(base + i);
      in_stb = 1'b1;
      tick();
    end
    in_stb = 1'b0;
  endtask

  task automatic pulse_dec(input int n);
    vit_out_valid = 1'b1;
    repeat (n) tick();
    vit_out_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int k = 0;
    while (busy && k < bound) begin
      tick();
      k++;
    end
    chk(tag, 32'(busy), 32'(0));
  endtask

  // Data entries carry a nonzero erase field; flush pairs carry zero.
  task automatic check_data(input string tag, input int q0, input int base, input int n);
    int j = 0;
    for (int k = q0; k < xq.size(); k++) begin
      if (xq[k][17:16] != 2'b00) begin
        if (j < n) chk($sformatf("%s_d%0d", tag, j), 32'(xq[k]), 32'(exp_word(pair_val(base + j))));
        j++;
      end
    end
    chk({tag, "_ndata"}, 32'(j), 32'(n));
  endtask

  initial begin
    int q0, d0, s0;
    reset = 1'b1; enable = 1'b1; start = 1'b0; in_stb = 1'b0; vit_out_valid = 1'b0;
    num_bits_to_decode = '0; in_bits = '0; in_erase = '0; vif.vit_tready = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_timeout", 32'(timeout), 32'(0));
    chk("rst_overflow", 32'(overflow), 32'(0));
    chk("rst_in_count", 32'(in_count), 32'(0));
    chk("rst_dec_count", 32'(dec_count), 32'(0));
    chk("rst_tvalid", 32'(vif.vit_tvalid), 32'(0));
    chk("rst_tdata", 32'(vif.vit_tdata), 32'(0));
    chk("rst_tuser", 32'(vif.vit_tuser), 32'(0));
    reset = 1'b0;
    tick();

    // Basic field of 24 pairs
    vif.vit_tready = 1'b1;
    q0 = xq.size(); d0 = done_cnt;
    do_start(24);
    chk("t1_busy", 32'(busy), 32'(1));
    feed(0, 24);
    pulse_dec(24);
    wait_idle("t1_idle", 60);
    chk("t1_done_pulses", 32'(done_cnt - d0), 32'(1));
    chk("t1_in_count", 32'(in_count), 32'(24));
    chk("t1_dec_count", 32'(dec_count), 32'(24));
    check_data("t1", q0, 0, 24);
    chk("t1_first_flush", (xq.size() > q0 + 24) ? 32'(xq[q0 + 24]) : 32'hFFFFFFFF, 32'h00000303);
    chk("t1_flush_seen", 32'(count_flush(q0) > 0), 32'(1));

    // Backpressure: ready one cycle in four
    q0 = xq.size(); d0 = done_cnt; s0 = stall_viol;
    do_start(8);
    for (int c = 0; c < 80; c++) begin
      vif.vit_tready = (c % 4 == 0);
      if (c < 8) begin
        {in_erase, in_bits} = pair_val(100 + c);
        in_stb = 1'b1;
      end else begin
        in_stb = 1'b0;
      end
      vit_out_valid = (c >= 44 && c < 52);
      tick();
      if (c > 8 && !busy) break;
    end
    vit_out_valid = 1'b0; in_stb = 1'b0; vif.vit_tready = 1'b1;
    chk("t2_idle", 32'(busy), 32'(0));
    chk("t2_overflow", 32'(overflow), 32'(0));
    chk("t2_stable", 32'(stall_viol - s0), 32'(0));
    chk("t2_done_pulses", 32'(done_cnt - d0), 32'(1));
    chk("t2_in_count", 32'(in_count), 32'(8));
    chk("t2_dec_count", 32'(dec_count), 32'(8));
    check_data("t2", q0, 100, 8);

    // Overflow: nine pairs into a stalled eight-deep FIFO
    vif.vit_tready = 1'b0;
    q0 = xq.size();
    do_start(16);
    feed(200, 8);
    chk("t3_ovf_at8", 32'(overflow), 32'(0));
    chk("t3_cnt_at8", 32'(in_count), 32'(8));
    feed(208, 1);
    chk("t3_ovf_at9", 32'(overflow), 32'(1));
    chk("t3_cnt_at9", 32'(in_count), 32'(9));
    chk("t3_tvalid_full", 32'(vif.vit_tvalid), 32'(1));
    vif.vit_tready = 1'b1;
    repeat (10) tick();
    check_data("t3", q0, 200, 8);
    chk("t3_tvalid_drained", 32'(vif.vit_tvalid), 32'(0));
    chk("t3_busy", 32'(busy), 32'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t3_ovf_cleared", 32'(overflow), 32'(0));
    chk("t3_rst_idle", 32'(busy), 32'(0));

    // Excess input beyond the target
    q0 = xq.size(); d0 = done_cnt;
    do_start(4);
    feed(300, 6);
    pulse_dec(4);
    wait_idle("t4_idle", 40);
    chk("t4_in_count", 32'(in_count), 32'(4));
    chk("t4_dec_count", 32'(dec_count), 32'(4));
    chk("t4_done_pulses", 32'(done_cnt - d0), 32'(1));
    check_data("t4", q0, 300, 4);

    // Zero target: FEED, FLUSH, DONE, IDLE on successive cycles
    d0 = done_cnt;
    do_start(0);
    chk("t5z_busy", 32'(busy), 32'(1));
    chk("t5z_tvalid_feed", 32'(vif.vit_tvalid), 32'(0));
    tick();
    chk("t5z_tvalid_flush", 32'(vif.vit_tvalid), 32'(1));
    chk("t5z_flush_data", 32'(vif.vit_tdata), 32'h0303);
    chk("t5z_flush_user", 32'(vif.vit_tuser), 32'h00);
    chk("t5z_no_done_yet", 32'(done), 32'(0));
    tick();
    chk("t5z_done", 32'(done), 32'(1));
    chk("t5z_tvalid_done", 32'(vif.vit_tvalid), 32'(0));
    tick();
    chk("t5z_idle", 32'(busy), 32'(0));
    chk("t5z_done_low", 32'(done), 32'(0));
    chk("t5z_done_pulses", 32'(done_cnt - d0), 32'(1));

    // Timeout: decoder never produces output bits
    q0 = xq.size(); d0 = done_cnt;
    do_start(2);
    feed(400, 2);
    wait_idle("t6_idle", 400);
    chk("t6_timeout", 32'(timeout), 32'(1));
    chk("t6_flush_pairs", 32'(count_flush(q0)), 32'(256));
    chk("t6_done_pulses", 32'(done_cnt - d0), 32'(1));
    check_data("t6", q0, 400, 2);
    tick();
    chk("t6_timeout_sticky", 32'(timeout), 32'(1));

    // Enable low for five cycles mid-FEED
    q0 = xq.size(); d0 = done_cnt;
    do_start(6);
    chk("t7_timeout_cleared", 32'(timeout), 32'(0));
    feed(500, 3);
    enable = 1'b0;
    {in_erase, in_bits} = pair_val(900);
    in_stb = 1'b1;
    vit_out_valid = 1'b1;
    repeat (5) begin
      tick();
      chk("t7_tvalid_off", 32'(vif.vit_tvalid), 32'(0));
      chk("t7_in_frozen", 32'(in_count), 32'(3));
    end
    chk("t7_dec_frozen", 32'(dec_count), 32'(0));
    in_stb = 1'b0; vit_out_valid = 1'b0; enable = 1'b1;
    feed(503, 3);
    pulse_dec(6);
    wait_idle("t7_idle", 40);
    chk("t7_in_count", 32'(in_count), 32'(6));
    chk("t7_dec_count", 32'(dec_count), 32'(6));
    chk("t7_done_pulses", 32'(done_cnt - d0), 32'(1));
    check_data("t7", q0, 500, 6);

    // Reset while flushing
    d0 = done_cnt;
    do_start(2);
    feed(600, 2);
    repeat (3) tick();
    chk("t8_flushing", 32'(vif.vit_tdata), 32'h0303);
    chk("t8_tvalid", 32'(vif.vit_tvalid), 32'(1));
    reset = 1'b1;
    tick();
    chk("t8_busy", 32'(busy), 32'(0));
    chk("t8_tvalid_rst", 32'(vif.vit_tvalid), 32'(0));
    chk("t8_tdata_rst", 32'(vif.vit_tdata), 32'(0));
    chk("t8_in_count", 32'(in_count), 32'(0));
    chk("t8_dec_count", 32'(dec_count), 32'(0));
    reset = 1'b0;
    repeat (3) tick();
    chk("t8_no_done", 32'(done_cnt - d0), 32'(0));

    // Start pulse while busy is ignored
    q0 = xq.size(); d0 = done_cnt;
    do_start(4);
    feed(700, 1);
    num_bits_to_decode = 20'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t9_in_kept", 32'(in_count), 32'(1));
    feed(701, 3);
    chk("t9_in_count", 32'(in_count), 32'(4));
    pulse_dec(4);
    wait_idle("t9_idle", 40);
    chk("t9_done_pulses", 32'(done_cnt - d0), 32'(1));
    check_data("t9", q0, 700, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
